// File: rtl/if_fetch_unit_pkg.sv
// -----------------------------------------------------------------------------
// if_fetch_unit_pkg
// Shared pipeline constants for the instruction-fetch stage and its neighbours:
// default reset PC, NOP encoding, PC step and the IF/ID bubble values, plus a
// helper that forces a PC onto a word boundary.
// -----------------------------------------------------------------------------
package if_fetch_unit_pkg;

  localparam logic [31:0] PKG_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;  // addi x0, x0, 0
  localparam logic [31:0] PC_INC       = 32'd4;
  localparam logic [31:0] BUBBLE_PC    = 32'h0000_0000;
  localparam logic [31:0] BUBBLE_INSTR = 32'h0000_0000;

  // Instruction fetches are always word aligned; the low two bits are dropped.
  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_fetch_unit_fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
// DEPTH-entry circular buffer of {pc, instr, filled}. Entries are allocated in
// request order, filled in response order (imem is in-order, so fills walk the
// same sequence) and popped from the head once filled.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   i_flush           empty the queue (all pointers and counts to zero)
//   i_alloc/i_alloc_pc  reserve the entry at the alloc pointer for this PC
//   i_fill/i_fill_data  write the instruction into the oldest unfilled entry
//   i_pop             retire the head entry (caller guarantees it is filled)
//   o_head_valid      head entry filled
//   o_head_pc/instr   head entry contents, bubble values when not valid
//   o_alloc_cnt       entries allocated and not yet popped
//   o_unfilled        entries allocated and not yet filled
// -----------------------------------------------------------------------------
module fetch_queue
  import if_fetch_unit_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_flush,
  input  logic                         i_alloc,
  input  logic [31:0]                  i_alloc_pc,
  input  logic                         i_fill,
  input  logic [31:0]                  i_fill_data,
  input  logic                         i_pop,
  output logic                         o_head_valid,
  output logic [31:0]                  o_head_pc,
  output logic [31:0]                  o_head_instr,
  output logic [$clog2(DEPTH+1)-1:0]   o_alloc_cnt,
  output logic [$clog2(DEPTH+1)-1:0]   o_unfilled
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [31:0]      r_pc    [DEPTH];
  logic [31:0]      r_instr [DEPTH];
  logic [DEPTH-1:0] r_filled;
  logic [AW-1:0]    r_alloc_ptr;
  logic [AW-1:0]    r_fill_ptr;
  logic [AW-1:0]    r_head_ptr;
  logic [CW-1:0]    r_alloc_cnt;
  logic [CW-1:0]    r_unfilled;

  // Control state: pointers, counts and filled flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_alloc_ptr <= '0;
      r_fill_ptr  <= '0;
      r_head_ptr  <= '0;
      r_alloc_cnt <= '0;
      r_unfilled  <= '0;
      r_filled    <= '0;
    end else if (i_flush) begin
      r_alloc_ptr <= '0;
      r_fill_ptr  <= '0;
      r_head_ptr  <= '0;
      r_alloc_cnt <= '0;
      r_unfilled  <= '0;
      r_filled    <= '0;
    end else begin
      // Alloc, fill and pop always touch distinct entries: alloc never
      // reaches the head while entries are live, a fill targets an unfilled
      // entry and a pop a filled one.
      if (i_alloc) begin
        r_filled[r_alloc_ptr] <= 1'b0;
        r_alloc_ptr           <= r_alloc_ptr + AW'(1);
      end
      if (i_fill) begin
        r_filled[r_fill_ptr] <= 1'b1;
        r_fill_ptr           <= r_fill_ptr + AW'(1);
      end
      if (i_pop) begin
        r_filled[r_head_ptr] <= 1'b0;
        r_head_ptr           <= r_head_ptr + AW'(1);
      end
      r_alloc_cnt <= r_alloc_cnt + CW'(i_alloc) - CW'(i_pop);
      r_unfilled  <= r_unfilled + CW'(i_alloc) - CW'(i_fill);
    end
  end

  // Payload storage carries no reset; validity comes from r_filled.
  always_ff @(posedge clk) begin
    if (i_alloc && !i_flush) begin
      r_pc[r_alloc_ptr] <= i_alloc_pc;
    end
    if (i_fill && !i_flush) begin
      r_instr[r_fill_ptr] <= i_fill_data;
    end
  end

  assign o_head_valid = r_filled[r_head_ptr];
  assign o_head_pc    = o_head_valid ? r_pc[r_head_ptr]    : BUBBLE_PC;
  assign o_head_instr = o_head_valid ? r_instr[r_head_ptr] : BUBBLE_INSTR;
  assign o_alloc_cnt  = r_alloc_cnt;
  assign o_unfilled   = r_unfilled;

endmodule

// File: rtl/if_fetch_unit.sv
// -----------------------------------------------------------------------------
// if_fetch_unit
// Instruction-fetch stage. Owns the PC, issues in-order word fetches to imem,
// parks returned words in a PC-tagged queue and presents one {pc, instr} per
// cycle to IF/ID. A redirect from EX empties the queue, restarts fetch at the
// target and silently drops responses to requests issued before it.
//
// Ports
//   clk, rst                      clock, asynchronous active-high reset
//   imem_req_valid/ready/addr     fetch request handshake, word-aligned address
//   imem_rsp_valid/data           in-order instruction response
//   redirect_valid/pc             branch/jump restart from EX (pc[1:0] ignored)
//   if_valid/pc/instr, if_ready   head of queue towards IF/ID, 0 when empty
// -----------------------------------------------------------------------------
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = PKG_RESET_PC,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  input  logic        if_ready
);

  localparam int          CW    = $clog2(DEPTH + 1);
  localparam logic [CW:0] LIMIT = (CW+1)'(DEPTH);

  logic [31:0]   r_pc;
  logic [CW-1:0] r_discard;
  logic [CW-1:0] w_discard_nxt;
  logic [CW-1:0] w_alloc_cnt;
  logic [CW-1:0] w_unfilled;
  logic [CW:0]   w_inflight;
  logic          w_req_fire;
  logic          w_fill;
  logic          w_pop;

  // Stale responses still owed by imem occupy request slots too, so a
  // redirect cannot push the number of outstanding requests past DEPTH.
  assign w_inflight     = {1'b0, w_alloc_cnt} + {1'b0, r_discard};
  assign imem_req_valid = !rst && !redirect_valid && (w_inflight < LIMIT);
  assign imem_req_addr  = r_pc;
  assign w_req_fire     = imem_req_valid && imem_req_ready;

  assign w_fill = imem_rsp_valid && !redirect_valid &&
                  (r_discard == '0) && (w_unfilled != '0);
  assign w_pop  = if_valid && if_ready && !redirect_valid;

  // On redirect every outstanding request becomes stale; a response arriving
  // in that same cycle is one of them and is consumed immediately.
  always_comb begin
    w_discard_nxt = r_discard;
    if (redirect_valid) begin
      w_discard_nxt = r_discard + w_unfilled - CW'(imem_rsp_valid);
    end else if (imem_rsp_valid && (r_discard != '0)) begin
      w_discard_nxt = r_discard - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc      <= align_pc(RESET_PC);
      r_discard <= '0;
    end else begin
      r_discard <= w_discard_nxt;
      if (redirect_valid) begin
        r_pc <= align_pc(redirect_pc);
      end else if (w_req_fire) begin
        r_pc <= r_pc + PC_INC;
      end
    end
  end

  fetch_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .clk          (clk),
    .rst          (rst),
    .i_flush      (redirect_valid),
    .i_alloc      (w_req_fire),
    .i_alloc_pc   (r_pc),
    .i_fill       (w_fill),
    .i_fill_data  (imem_rsp_data),
    .i_pop        (w_pop),
    .o_head_valid (if_valid),
    .o_head_pc    (if_pc),
    .o_head_instr (if_instr),
    .o_alloc_cnt  (w_alloc_cnt),
    .o_unfilled   (w_unfilled)
  );

  // A response with no request outstanding means imem broke its contract.
  always_ff @(posedge clk) begin
    if (!rst && imem_rsp_valid) begin
      assert ((r_discard != '0) || (w_unfilled != '0));
    end
  end

endmodule
